// File: rtl/signature_checker.sv
// Signature checker: counts RUN cycles, captures the upstream signature when the
// stimulus counter fills, then compares it against the golden value.
// Optional RUN timeout is enabled by defining macro SIG_CHECK_TIMEOUT_EN.
module signature_checker #(
  parameter int SIG_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 300
) (
  input  logic                 clk,
  input  logic                 clear,
  input  logic [SIG_WIDTH-1:0] signature_in,
  input  logic                 counter_full_bar,
  input  logic [SIG_WIDTH-1:0] expected_signature,
  output logic [SIG_WIDTH-1:0] captured_signature,
  output logic [8:0]           cycle_count,
  output logic                 done,
  output logic                 pass,
  output logic                 fail,
  output logic                 timeout,
  output logic [1:0]           state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    COMPARE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [8:0] COUNT_MAX    = 9'd511;
  localparam logic [8:0] TIMEOUT_LAST = 9'(TIMEOUT_CYCLES - 1);

  state_t state_q;
  logic   timeout_flag;

  assign state = state_q;

`ifdef SIG_CHECK_TIMEOUT_EN
  assign timeout = timeout_flag;
`else
  assign timeout = 1'b0;
`endif

  // Main FSM; all result outputs are registered here and frozen once in DONE.
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q            <= IDLE;
      captured_signature <= '0;
      cycle_count        <= 9'd0;
      done               <= 1'b0;
      pass               <= 1'b0;
      fail               <= 1'b0;
      timeout_flag       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_q <= RUN;
        end
        RUN: begin
          if (!counter_full_bar) begin
            captured_signature <= signature_in;
            state_q            <= COMPARE;
          end
`ifdef SIG_CHECK_TIMEOUT_EN
          else if (cycle_count == TIMEOUT_LAST) begin
            captured_signature <= signature_in;
            done               <= 1'b1;
            fail               <= 1'b1;
            pass               <= 1'b0;
            timeout_flag       <= 1'b1;
            state_q            <= DONE;
          end
`endif
          else if (cycle_count != COUNT_MAX) begin
            cycle_count <= cycle_count + 9'd1;
          end else begin
            cycle_count <= cycle_count;
          end
        end
        COMPARE: begin
          // A signature that moved after capture is treated as unstable and fails.
          done    <= 1'b1;
          state_q <= DONE;
          if ((captured_signature == expected_signature) &&
              (signature_in == captured_signature)) begin
            pass <= 1'b1;
            fail <= 1'b0;
          end else begin
            pass <= 1'b0;
            fail <= 1'b1;
          end
        end
        DONE: begin
          state_q <= DONE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_signature_checker.sv
// Self-checking bench for signature_checker: a directed vector table plus
// hand-written multi-cycle sequences (long runs, mid-run clear, timeout).
module tb_signature_checker;

  logic        clk;
  logic        clear;
  logic [15:0] signature_in;
  logic        counter_full_bar;
  logic [15:0] expected_signature;
  logic [15:0] captured_signature;
  logic [8:0]  cycle_count;
  logic        done;
  logic        pass;
  logic        fail;
  logic        timeout;
  logic [1:0]  state;

  int total;
  int bad;

  signature_checker #(.SIG_WIDTH(16), .TIMEOUT_CYCLES(300)) dut (
    .clk                (clk),
    .clear              (clear),
    .signature_in       (signature_in),
    .counter_full_bar   (counter_full_bar),
    .expected_signature (expected_signature),
    .captured_signature (captured_signature),
    .cycle_count        (cycle_count),
    .done               (done),
    .pass               (pass),
    .fail               (fail),
    .timeout            (timeout),
    .state              (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        clr;
    logic        cfb;
    logic [15:0] sig;
    logic [15:0] exp_sig;
    logic [1:0]  st;
    logic        d;
    logic        p;
    logic        f;
    logic [8:0]  cc;
    logic [15:0] cap;
  } vec_t;

  vec_t vecs[18];

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [1:0] st, input logic d,
                     input logic p, input logic f, input logic t,
                     input logic [8:0] cc, input logic [15:0] cap);
    total++;
    if (state !== st || done !== d || pass !== p || fail !== f || timeout !== t ||
        cycle_count !== cc || captured_signature !== cap) begin
      bad++;
      $display("FAIL %s: got st=%0d done=%b pass=%b fail=%b to=%b cc=%0d cap=%h, want st=%0d done=%b pass=%b fail=%b to=%b cc=%0d cap=%h",
               name, state, done, pass, fail, timeout, cycle_count, captured_signature,
               st, d, p, f, t, cc, cap);
    end
    total++;
    if (pass === 1'b1 && fail === 1'b1) begin
      bad++;
      $display("FAIL %s_exclusive: got pass=1 fail=1, want not both", name);
    end
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      counter_full_bar = 1'b1;
      step();
    end
  endtask

  // Clear, enter RUN, count n cycles, capture, optionally change the signature in COMPARE.
  task automatic signature_run(input logic [15:0] sig, input logic [15:0] exp_sig,
                               input int n, input logic [15:0] compare_sig);
    signature_in       = sig;
    expected_signature = exp_sig;
    clear = 1'b1; counter_full_bar = 1'b1;
    step();
    clear = 1'b0;
    step();
    run_cycles(n);
    counter_full_bar = 1'b0;
    step();
    signature_in = compare_sig;
    step();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    clear = 1'b1;
    counter_full_bar = 1'b1;
    signature_in = 16'h0000;
    expected_signature = 16'h0000;

    //          clr   cfb   sig       exp       st    d     p     f     cc     cap
    vecs[0]  = '{1'b1, 1'b1, 16'h1234, 16'h1234, 2'd0, 1'b0, 1'b0, 1'b0, 9'd0, 16'h0000};
    vecs[1]  = '{1'b0, 1'b0, 16'hABCD, 16'hABCD, 2'd1, 1'b0, 1'b0, 1'b0, 9'd0, 16'h0000};
    vecs[2]  = '{1'b0, 1'b0, 16'hABCD, 16'hABCD, 2'd2, 1'b0, 1'b0, 1'b0, 9'd0, 16'hABCD};
    vecs[3]  = '{1'b0, 1'b1, 16'hABCD, 16'hABCD, 2'd3, 1'b1, 1'b1, 1'b0, 9'd0, 16'hABCD};
    vecs[4]  = '{1'b0, 1'b0, 16'h0000, 16'hABCD, 2'd3, 1'b1, 1'b1, 1'b0, 9'd0, 16'hABCD};
    vecs[5]  = '{1'b1, 1'b1, 16'h0000, 16'h0001, 2'd0, 1'b0, 1'b0, 1'b0, 9'd0, 16'h0000};
    vecs[6]  = '{1'b0, 1'b1, 16'h8001, 16'h0001, 2'd1, 1'b0, 1'b0, 1'b0, 9'd0, 16'h0000};
    vecs[7]  = '{1'b0, 1'b1, 16'h8001, 16'h0001, 2'd1, 1'b0, 1'b0, 1'b0, 9'd1, 16'h0000};
    vecs[8]  = '{1'b0, 1'b1, 16'h8001, 16'h0001, 2'd1, 1'b0, 1'b0, 1'b0, 9'd2, 16'h0000};
    vecs[9]  = '{1'b0, 1'b0, 16'h8001, 16'h0001, 2'd2, 1'b0, 1'b0, 1'b0, 9'd2, 16'h8001};
    vecs[10] = '{1'b0, 1'b1, 16'h8001, 16'h0001, 2'd3, 1'b1, 1'b0, 1'b1, 9'd2, 16'h8001};
    vecs[11] = '{1'b1, 1'b0, 16'h5555, 16'h5555, 2'd0, 1'b0, 1'b0, 1'b0, 9'd0, 16'h0000};
    vecs[12] = '{1'b0, 1'b1, 16'h5555, 16'h5555, 2'd1, 1'b0, 1'b0, 1'b0, 9'd0, 16'h0000};
    vecs[13] = '{1'b0, 1'b1, 16'h5555, 16'h5555, 2'd1, 1'b0, 1'b0, 1'b0, 9'd1, 16'h0000};
    vecs[14] = '{1'b1, 1'b1, 16'h5555, 16'h5555, 2'd0, 1'b0, 1'b0, 1'b0, 9'd0, 16'h0000};
    vecs[15] = '{1'b0, 1'b0, 16'h5555, 16'h5555, 2'd1, 1'b0, 1'b0, 1'b0, 9'd0, 16'h0000};
    vecs[16] = '{1'b0, 1'b0, 16'h5555, 16'h5555, 2'd2, 1'b0, 1'b0, 1'b0, 9'd0, 16'h5555};
    vecs[17] = '{1'b1, 1'b0, 16'h5555, 16'h5555, 2'd0, 1'b0, 1'b0, 1'b0, 9'd0, 16'h0000};

    for (int i = 0; i < 18; i++) begin
      clear              = vecs[i].clr;
      counter_full_bar   = vecs[i].cfb;
      signature_in       = vecs[i].sig;
      expected_signature = vecs[i].exp_sig;
      step();
      chk($sformatf("vec%0d", i), vecs[i].st, vecs[i].d, vecs[i].p, vecs[i].f, 1'b0,
          vecs[i].cc, vecs[i].cap);
    end

    // Clear held high for several cycles keeps IDLE regardless of counter_full_bar.
    clear = 1'b1; counter_full_bar = 1'b0; signature_in = 16'hFFFF;
    step(); step(); step();
    chk("clear_held", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 9'd0, 16'h0000);

    // Pass case with exact two-edge latency check.
    signature_in = 16'h1234; expected_signature = 16'h1234;
    clear = 1'b1; counter_full_bar = 1'b1;
    step();
    clear = 1'b0;
    step();
    run_cycles(255);
    chk("run255", 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 9'd255, 16'h0000);
    counter_full_bar = 1'b0;
    step();
    chk("latency_edge1", 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 9'd255, 16'h1234);
    step();
    chk("pass_case", 2'd3, 1'b1, 1'b1, 1'b0, 1'b0, 9'd255, 16'h1234);

    signature_run(16'h1234, 16'h1235, 255, 16'h1234);
    chk("mismatch_case", 2'd3, 1'b1, 1'b0, 1'b1, 1'b0, 9'd255, 16'h1234);

    signature_run(16'h1234, 16'h1234, 255, 16'hBEEF);
    chk("unstable_sig", 2'd3, 1'b1, 1'b0, 1'b1, 1'b0, 9'd255, 16'h1234);

    // Clear in the middle of a run, then a fresh run of 255 cycles.
    signature_in = 16'h1234; expected_signature = 16'h1234;
    clear = 1'b1; counter_full_bar = 1'b1;
    step();
    clear = 1'b0;
    step();
    run_cycles(100);
    chk("mid_run100", 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 9'd100, 16'h0000);
    clear = 1'b1;
    step();
    chk("mid_run_clear", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 9'd0, 16'h0000);
    clear = 1'b0;
    step();
    run_cycles(255);
    counter_full_bar = 1'b0;
    step(); step();
    chk("after_clear_run", 2'd3, 1'b1, 1'b1, 1'b0, 1'b0, 9'd255, 16'h1234);

    // Clear pulse lying entirely between two rising edges is ignored.
    @(posedge clk);
    #2 clear = 1'b1;
    #5 clear = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("glitch_clear", 2'd3, 1'b1, 1'b1, 1'b0, 1'b0, 9'd255, 16'h1234);

`ifdef SIG_CHECK_TIMEOUT_EN
    begin
      int n;
      signature_in = 16'h4321; expected_signature = 16'h4321;
      clear = 1'b1; counter_full_bar = 1'b1;
      step();
      clear = 1'b0;
      step();
      n = 0;
      while (done !== 1'b1 && n < 400) begin
        step();
        n++;
      end
      total++;
      if (done !== 1'b1) begin
        bad++;
        $display("FAIL timeout_wait: got done=%b after %0d cycles, want done=1", done, n);
      end
      chk("timeout_case", 2'd3, 1'b1, 1'b0, 1'b1, 1'b1, 9'd299, 16'h4321);
    end
`else
    clear = 1'b1; counter_full_bar = 1'b1;
    step();
    clear = 1'b0;
    step();
    run_cycles(600);
    chk("no_timeout_sat", 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 9'd511, 16'h0000);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/signature_checker.md
SIGNATURE_CHECKER -- requirements
Module: signature_checker

Interface
REQ-001 SHALL have parameter SIG_WIDTH, default 16: width of the signature compared.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 300: RUN-cycle limit, used only when SIG_CHECK_TIMEOUT_EN is defined.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port clear  input  1: reset, synchronous, active-high, sampled only at the rising edge of clk.
REQ-005 SHALL have port signature_in  input  SIG_WIDTH: accumulator signature from the upstream stage.
REQ-006 SHALL have port counter_full_bar  input  1: low when the upstream stimulus counter is full and the signature is frozen.
REQ-007 SHALL have port expected_signature  input  SIG_WIDTH: golden value, treated as static during a run.
REQ-008 SHALL have port captured_signature  output  SIG_WIDTH: registered copy of signature_in at capture.
REQ-009 SHALL have port cycle_count  output  9: number of RUN cycles before capture.
REQ-010 SHALL have ports done, pass, fail, timeout  output  1 each: result flags.
REQ-011 SHALL have port state  output  2: current FSM state (IDLE=0, RUN=1, COMPARE=2, DONE=3).

Function
REQ-012 SHALL implement a four-state FSM: IDLE, RUN, COMPARE, DONE.
REQ-013 IDLE SHALL go to RUN at the first rising edge that samples clear=0.
REQ-014 RUN with counter_full_bar=1 SHALL stay in RUN and increment cycle_count, saturating at 511.
REQ-015 RUN with counter_full_bar=0 SHALL load captured_signature from signature_in, hold cycle_count and go to COMPARE at that same edge.
REQ-016 COMPARE SHALL go to DONE at the next edge and register done=1 there.
- pass=1, fail=0 if captured_signature equals expected_signature;
- pass=0, fail=1 otherwise.
REQ-017 Result latency SHALL be exactly 2 rising edges from the first edge that samples counter_full_bar=0 in RUN to done=1.
REQ-018 DONE SHALL hold all outputs unchanged until clear, regardless of signature_in and counter_full_bar.
REQ-019 In COMPARE, a signature_in value differing from captured_signature SHALL set fail=1 and pass=0 at the DONE transition, even if the captured value matched.
REQ-020 pass and fail SHALL never be 1 simultaneously.
REQ-021 Both pass and fail SHALL be 0 whenever done=0.
REQ-022 counter_full_bar=0 sampled in IDLE SHALL be ignored.
REQ-023 A counter_full_bar=0 on the first RUN edge SHALL capture with cycle_count=0.
REQ-024 The comparison SHALL use the full SIG_WIDTH bits, with no masking.

Reset
REQ-025 clear=1 at a rising edge SHALL force the following, from any state including mid-RUN and COMPARE:
- state=IDLE, captured_signature=0, cycle_count=0;
- done=0, pass=0, fail=0, timeout=0.
REQ-026 A clear pulse that contains no rising edge of clk SHALL have no effect.
REQ-027 While clear is held high, the block SHALL remain in IDLE with all outputs at their reset values.

Configuration
REQ-028 With macro SIG_CHECK_TIMEOUT_EN defined, RUN SHALL go directly to DONE when cycle_count reaches TIMEOUT_CYCLES-1 and counter_full_bar=1.
- That transition SHALL set done=1, fail=1, pass=0, timeout=1.
- captured_signature SHALL load signature_in at that edge.
REQ-029 With SIG_CHECK_TIMEOUT_EN undefined, timeout SHALL be constant 0 and RUN SHALL wait indefinitely for counter_full_bar=0.

Verification
REQ-030 Pass case: signature_in=16'h1234, expected=16'h1234, counter_full_bar low after 255 RUN cycles -> 2 edges later done=1, pass=1, cycle_count=255, captured=16'h1234.
REQ-031 Mismatch case: expected=16'h1235, otherwise as REQ-030 -> done=1, fail=1, pass=0.
REQ-032 Unstable signature: signature_in changes 16'h1234->16'hBEEF during COMPARE, expected=16'h1234 -> fail=1.
REQ-033 Reset mid-operation: clear high for 1 cycle at RUN cycle 100, then full after 255 further cycles -> cycle_count=255; a 0.5-cycle clear pulse between edges during DONE leaves outputs unchanged.
REQ-034 Timeout: with SIG_CHECK_TIMEOUT_EN defined and counter_full_bar held high -> done=1, timeout=1, fail=1, cycle_count=299.
REQ-035 No timeout: with SIG_CHECK_TIMEOUT_EN undefined and counter_full_bar held high for 600 cycles -> state=RUN, cycle_count=511, done=0.
